terminal_writer: RTL

TERMINAL_WRITER -- requirements
Module: terminal_writer

---
 rtl/term_pkg.sv | 54 +++++
 rtl/terminal_writer_if.sv | 25 ++
 rtl/term_cursor_ctr.sv | 61 ++++++
 rtl/terminal_writer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// Shared constants, video word layout and encodings for the text terminal writer.
// Imported by the interface, the cursor counter and the top level.
package term_pkg;

    localparam int TERM_COLS  = 40;
    localparam int TERM_ROWS  = 30;
    localparam int TERM_CELLS = TERM_COLS * TERM_ROWS;
    localparam int ADDR_W     = 11;
    localparam int WORD_W     = 16;

    localparam int BIT_CURSOR    = 14;
    localparam int BIT_BLINK     = 13;
    localparam int BIT_INVERTED  = 12;
    localparam int BIT_RED       = 11;
    localparam int BIT_GREEN     = 10;
    localparam int BIT_BLUE      = 9;
    localparam int BIT_INTENSITY = 8;

    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    typedef enum logic [3:0] {
        CLEAR_ALL, IDLE, PUT, CUR_RD, CUR_WR, OLD_RD, OLD_WR, SCR_RD, SCR_WR, SCR_CLR
    } state_t;

    typedef enum logic [1:0] {CMD_PRINT, CMD_NL, CMD_BS} cmd_t;

    typedef enum logic [2:0] {OP_NONE, OP_ADV, OP_NL, OP_BS, OP_HOME} cur_op_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
    endfunction

    // Attribute bits are placed one by one so the word layout lives only in the constants above.
    function automatic logic [WORD_W-1:0] make_word(input logic cursor, input logic [5:0] attr,
                                                    input logic [7:0] ch);
        logic [WORD_W-1:0] w;
        w                = '0;
        w[BIT_CURSOR]    = cursor;
        w[BIT_BLINK]     = attr[5];
        w[BIT_INVERTED]  = attr[4];
        w[BIT_RED]       = attr[3];
        w[BIT_GREEN]     = attr[2];
        w[BIT_BLUE]      = attr[1];
        w[BIT_INTENSITY] = attr[0];
        w[7:0]           = ch;
        return w;
    endfunction

endpackage

// File: rtl/terminal_writer_if.sv
// Character input handshake and video-RAM port of the terminal writer.
// master is the writer side, slave is the character source plus RAM.
interface terminal_writer_if;
    import term_pkg::*;

    logic              char_valid;
    logic [7:0]        char_data;
    logic [5:0]        char_attr;
    logic              char_ready;
    logic              we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;
    logic [WORD_W-1:0] ret_data;

    modport master (
        input  char_valid, char_data, char_attr, ret_data,
        output char_ready, we, mem_addr, mem_data
    );

    modport slave (
        output char_valid, char_data, char_attr, ret_data,
        input  char_ready, we, mem_addr, mem_data
    );

endinterface

// File: rtl/term_cursor_ctr.sv
// Cursor position keeper: row/col, wrap, backspace, and the linear cell address.
// The scroll flags say whether an advance or a newline would run off the last row.
module term_cursor_ctr
    import term_pkg::*;
#(
    parameter int COLS = TERM_COLS,
    parameter int ROWS = TERM_ROWS
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  cur_op_t           i_op,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_col_zero,
    output logic              o_scroll_adv,
    output logic              o_scroll_nl
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_col_last;
    logic          w_row_last;

    assign w_col_last   = (r_col == CW'(COLS - 1));
    assign w_row_last   = (r_row == RW'(ROWS - 1));
    assign o_col_zero   = (r_col == '0);
    assign o_scroll_adv = w_col_last && w_row_last;
    assign o_scroll_nl  = w_row_last;
    assign o_addr       = ADDR_W'(r_row) * ADDR_W'(COLS) + ADDR_W'(r_col);

    // The row saturates at the bottom; the writer scrolls the RAM contents instead.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            case (i_op)
                OP_ADV: begin
                    if (w_col_last) begin
                        r_col <= '0;
                        if (!w_row_last) r_row <= r_row + RW'(1);
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end
                OP_NL: begin
                    r_col <= '0;
                    if (!w_row_last) r_row <= r_row + RW'(1);
                end
                OP_BS:   if (!o_col_zero) r_col <= r_col - CW'(1);
                OP_HOME: begin
                    r_col <= '0;
                    r_row <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/terminal_writer.sv
// Text terminal writer: turns a character stream into video-RAM cell writes,
// handling cursor drawing, newline, backspace, form feed and scrolling.
module terminal_writer
    import term_pkg::*;
#(
    parameter int         COLS     = TERM_COLS,
    parameter int         ROWS     = TERM_ROWS,
    parameter logic [5:0] DEF_ATTR = 6'b001111
) (
    input logic               sys_clk,
    input logic               rst,
    terminal_writer_if.master bus
);
    localparam int                CELLS     = COLS * ROWS;
    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CELLS_A   = ADDR_W'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(CELLS - COLS);

    state_t            r_state, w_next;
    cmd_t              r_cmd, w_cmd_next;
    logic [ADDR_W-1:0] r_idx, w_idx_next;
    logic [7:0]        r_char;
    logic [5:0]        r_attr;
    logic              w_accept;
    cur_op_t           w_op;
    logic [ADDR_W-1:0] w_cur_addr;
    logic              w_col_zero, w_scroll_adv, w_scroll_nl;

    term_cursor_ctr #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .i_op         (w_op),
        .o_addr       (w_cur_addr),
        .o_col_zero   (w_col_zero),
        .o_scroll_adv (w_scroll_adv),
        .o_scroll_nl  (w_scroll_nl)
    );

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR_ALL;
            r_cmd   <= CMD_PRINT;
            r_idx   <= '0;
            r_char  <= '0;
            r_attr  <= DEF_ATTR;
        end else begin
            r_state <= w_next;
            r_cmd   <= w_cmd_next;
            r_idx   <= w_idx_next;
            if (w_accept) begin
                r_char <= bus.char_data;
                r_attr <= bus.char_attr;
            end
        end
    end

    // Outputs are gated by rst so the RAM port goes quiet the moment reset is asserted.
    // r_idx sweeps the clear, the scroll copy and the last-row blanking.
    always_comb begin
        w_next         = r_state;
        w_cmd_next     = r_cmd;
        w_idx_next     = r_idx;
        w_op           = OP_NONE;
        w_accept       = 1'b0;
        bus.char_ready = 1'b0;
        bus.we         = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_data   = '0;
        if (!rst) begin
            case (r_state)
                CLEAR_ALL: begin
                    bus.we = 1'b1;
                    if (r_idx == CELLS_A) begin
                        bus.mem_data = make_word(1'b1, r_attr, 8'h00);
                        w_idx_next   = '0;
                        w_next       = IDLE;
                    end else begin
                        bus.mem_addr = r_idx;
                        w_idx_next   = r_idx + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    bus.char_ready = 1'b1;
                    if (bus.char_valid) begin
                        w_accept = 1'b1;
                        if (is_printable(bus.char_data)) begin
                            w_cmd_next = CMD_PRINT;
                            w_next     = PUT;
                        end else if (bus.char_data == CH_CR || bus.char_data == CH_LF) begin
                            w_cmd_next = CMD_NL;
                            w_next     = OLD_RD;
                        end else if (bus.char_data == CH_BS) begin
                            w_cmd_next = CMD_BS;
                            w_next     = w_col_zero ? CUR_RD : OLD_RD;
                        end else if (bus.char_data == CH_FF) begin
                            w_op       = OP_HOME;
                            w_idx_next = '0;
                            w_next     = CLEAR_ALL;
                        end
                    end
                end
                PUT: begin
                    bus.we       = 1'b1;
                    bus.mem_addr = w_cur_addr;
                    bus.mem_data = (r_cmd == CMD_BS) ? '0 : make_word(1'b0, r_attr, r_char);
                    w_next       = CUR_RD;
                    if (r_cmd == CMD_PRINT) begin
                        w_op = OP_ADV;
                        if (w_scroll_adv) begin
                            w_idx_next = COLS_A;
                            w_next     = SCR_RD;
                        end
                    end
                end
                OLD_RD: begin
                    bus.mem_addr = w_cur_addr;
                    w_next       = OLD_WR;
                end
                OLD_WR: begin
                    bus.we                   = 1'b1;
                    bus.mem_addr             = w_cur_addr;
                    bus.mem_data             = bus.ret_data;
                    bus.mem_data[BIT_CURSOR] = 1'b0;
                    if (r_cmd == CMD_BS) begin
                        w_op   = OP_BS;
                        w_next = PUT;
                    end else begin
                        w_op   = OP_NL;
                        w_next = CUR_RD;
                        if (w_scroll_nl) begin
                            w_idx_next = COLS_A;
                            w_next     = SCR_RD;
                        end
                    end
                end
                SCR_RD: begin
                    bus.mem_addr = r_idx;
                    w_next       = SCR_WR;
                end
                SCR_WR: begin
                    bus.we       = 1'b1;
                    bus.mem_addr = r_idx - COLS_A;
                    bus.mem_data = bus.ret_data;
                    if (r_idx == LAST_CELL) begin
                        w_idx_next = LAST_ROW;
                        w_next     = SCR_CLR;
                    end else begin
                        w_idx_next = r_idx + ADDR_W'(1);
                        w_next     = SCR_RD;
                    end
                end
                SCR_CLR: begin
                    bus.we       = 1'b1;
                    bus.mem_addr = r_idx;
                    if (r_idx == LAST_CELL) begin
                        w_next = CUR_RD;
                    end else begin
                        w_idx_next = r_idx + ADDR_W'(1);
                    end
                end
                CUR_RD: begin
                    bus.mem_addr = w_cur_addr;
                    w_next       = CUR_WR;
                end
                CUR_WR: begin
                    bus.we       = 1'b1;
                    bus.mem_addr = w_cur_addr;
                    bus.mem_data = make_word(1'b1, r_attr, bus.ret_data[7:0]);
                    w_next       = IDLE;
                end
                default: begin
                    w_idx_next = '0;
                    w_next     = CLEAR_ALL;
                end
            endcase
        end
    end

endmodule
